// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type and I2S capture FSM states
package audio_pkg;
  localparam int AUDIO_WIDTH = 24;
  typedef logic signed [AUDIO_WIDTH-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, WAIT_LEFT, SHIFT, PAD} i2s_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing one asynchronous bit into the clk domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: deserializes an asynchronous I2S stream into left/right sample pairs
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int WIDTH       = AUDIO_WIDTH,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sclk_in,
  input  logic                    lrclk_in,
  input  logic                    sdata_in,
  output logic signed [WIDTH-1:0] left_out,
  output logic signed [WIDTH-1:0] right_out,
  output logic                    sample_valid,
  output logic                    frame_error
);
  localparam int CW = $clog2(SLOT_BITS + 1);
  logic sck_s, lr_s, sd_s;
  logic sck_prev, sck_rise, lr_q, sd_q, lr_prev;
  logic chan, word_done, hold_ok, boundary;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg, left_hold;
  i2s_state_t state;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk, .rst_n(reset), .d(sclk_in),  .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lr  (.clk, .rst_n(reset), .d(lrclk_in), .q(lr_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd  (.clk, .rst_n(reset), .d(sdata_in), .q(sd_s));

  // lrclk/sdata are latched with the rise so the FSM sees a stable bit one clk later
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sck_prev <= 1'b0;
      sck_rise <= 1'b0;
      lr_q     <= 1'b0;
      sd_q     <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      sck_rise <= sck_s & ~sck_prev;
      if (sck_s & ~sck_prev) begin
        lr_q <= lr_s;
        sd_q <= sd_s;
      end
    end

  assign boundary = sck_rise && (lr_q != lr_prev);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      chan         <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      word_done    <= 1'b0;
      hold_ok      <= 1'b0;
      lr_prev      <= 1'b0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      word_done    <= 1'b0;
      if (sck_rise) lr_prev <= lr_q;
      if (!enable) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        hold_ok     <= 1'b0;
        frame_error <= 1'b0;
      end else begin
        if (word_done) begin
          if (!chan) begin
            left_hold <= shreg;
            hold_ok   <= 1'b1;
          end else if (hold_ok) begin
            left_out     <= left_hold;
            right_out    <= shreg;
            sample_valid <= 1'b1;
            hold_ok      <= 1'b0;
          end
        end
        case (state)
          IDLE: state <= WAIT_LEFT;
          WAIT_LEFT:
            if (boundary && !lr_q) begin
              chan    <= 1'b0;
              bit_cnt <= '0;
              hold_ok <= 1'b0;
              state   <= SHIFT;
            end
          SHIFT:
            if (boundary) begin
              // short slot: drop the partial word and realign on the new channel
              frame_error <= 1'b1;
              chan        <= lr_q;
              bit_cnt     <= '0;
              hold_ok     <= 1'b0;
            end else if (sck_rise) begin
              shreg   <= {shreg[WIDTH-2:0], sd_q};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CW'(WIDTH - 1)) begin
                word_done <= 1'b1;
                state     <= PAD;
              end
            end
          PAD:
            if (boundary) begin
              chan    <= lr_q;
              bit_cnt <= '0;
              state   <= SHIFT;
              if (!lr_q) hold_ok <= 1'b0;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized I2S slot stream checked by a slot-level scoreboard model
module tb_i2s_receiver;
  import audio_pkg::*;
  localparam int W = 24, SLOT = 32, SS = 2;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic sclk_in = 1'b0, lrclk_in = 1'b0, sdata_in = 1'b0;
  logic signed [W-1:0] left_out, right_out;
  logic sample_valid, frame_error;

  int errors = 0, checks = 0, cyc = 0, rise_edge = 0;
  bit stim_done = 1'b0;
  sample_t q_l[$], q_r[$];
  sample_t exp_l, exp_r, m_hold;
  bit m_prev_lr = 1'b0, m_aligned = 1'b0, m_hold_ok = 1'b0, m_short = 1'b0, m_err = 1'b0;

  i2s_receiver #(.WIDTH(W), .SLOT_BITS(SLOT), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sclk_in(sclk_in), .lrclk_in(lrclk_in), .sdata_in(sdata_in),
    .left_out(left_out), .right_out(right_out),
    .sample_valid(sample_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // one bit-clock period: 4 clks low with data set up, 4 clks high
  task automatic send_bit(input bit lr, input bit d);
    sclk_in = 1'b0; lrclk_in = lr; sdata_in = d;
    repeat (4) @(negedge clk);
    sclk_in = 1'b1;
    rise_edge = cyc + 1;
    repeat (4) @(negedge clk);
  endtask

  function automatic int rnd_len();
    return ($urandom_range(5) == 0) ? int'($urandom_range(W - 1, 1)) : int'($urandom_range(W + 12, W));
  endfunction

  // slot = delay bit + nbits bits; first W of those carry data MSB first
  task automatic slot(input bit lr, input sample_t data, input int nbits,
                      input int ev_at = -1, input bit ev_rst = 1'b0);
    bit bnd, push_it;
    bnd = (lr != m_prev_lr);
    m_prev_lr = lr;
    push_it = 1'b0;
    if (bnd && m_short) m_err = 1'b1;
    if (bnd) m_short = 1'b0;
    if (bnd && !lr) begin m_aligned = 1'b1; m_hold_ok = 1'b0; end
    if (ev_at < 0 && m_aligned && bnd) begin
      if (nbits < W) begin m_short = 1'b1; m_hold_ok = 1'b0; end
      else if (!lr) begin m_hold = data; m_hold_ok = 1'b1; end
      else begin push_it = m_hold_ok; m_hold_ok = 1'b0; end
    end
    for (int i = 0; i <= nbits; i++) begin
      bit d;
      d = (i >= 1 && i <= W) ? data[W-i] : 1'($urandom_range(1));
      if (i == ev_at) begin
        m_aligned = 1'b0; m_hold_ok = 1'b0; m_short = 1'b0; m_err = 1'b0;
        if (ev_rst) begin
          reset = 1'b0;
          #1;
          chk("async_rst_left", int'(left_out), 0);
          chk("async_rst_right", int'(right_out), 0);
          chk("async_rst_valid", int'(sample_valid), 0);
          chk("async_rst_err", int'(frame_error), 0);
        end else enable = 1'b0;
      end
      send_bit(lr, d);
      if (i == ev_at) begin
        if (!ev_rst) begin
          chk("disable_err", int'(frame_error), 0);
          chk("disable_valid", int'(sample_valid), 0);
        end
        reset = 1'b1;
        enable = 1'b1;
      end
      if (i == 0) begin
        chk("frame_error", int'(frame_error), int'(m_err));
        chk("pending_pairs", q_l.size(), 0);
        if (push_it) begin q_l.push_back(m_hold); q_r.push_back(data); end
      end
    end
  endtask

  initial begin
    fork
      begin : stim
        repeat (3) @(negedge clk);
        chk("reset_left", int'(left_out), 0);
        chk("reset_right", int'(right_out), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_err", int'(frame_error), 0);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        slot(1'b1, 24'h123456, SLOT - 1);
        slot(1'b0, 24'h7FFFFF, SLOT - 1);
        slot(1'b1, 24'h800001, SLOT - 1);
        slot(1'b0, 24'h000001, SLOT - 1);
        slot(1'b1, 24'hFFFFFF, SLOT - 1);
        chk("err_clean", int'(frame_error), 0);
        slot(1'b0, sample_t'($urandom), 20);
        slot(1'b1, 24'h0000AA, SLOT - 1);
        slot(1'b0, 24'h111111, SLOT - 1);
        slot(1'b1, 24'h222222, SLOT - 1);
        chk("err_sticky", int'(frame_error), 1);
        for (int f = 0; f < 12; f++) begin
          slot(1'b0, sample_t'($urandom), rnd_len());
          slot(1'b1, sample_t'($urandom), rnd_len());
        end
        slot(1'b0, 24'h0ABCDE, SLOT - 1);
        slot(1'b1, 24'h054321, SLOT - 1);
        slot(1'b0, sample_t'($urandom), SLOT - 1);
        slot(1'b1, sample_t'($urandom), SLOT - 1, 10);
        chk("hold_left_after_disable", int'(left_out), 'h0ABCDE);
        chk("hold_right_after_disable", int'(right_out), 'h054321);
        slot(1'b0, sample_t'($urandom), SLOT - 1);
        slot(1'b1, sample_t'($urandom), SLOT - 1);
        slot(1'b0, sample_t'($urandom), SLOT - 1, 5);
        slot(1'b1, sample_t'($urandom), SLOT - 1);
        slot(1'b0, sample_t'($urandom), SLOT + 4);
        slot(1'b1, sample_t'($urandom), W);
        slot(1'b0, sample_t'($urandom), SLOT - 1, 12, 1'b1);
        slot(1'b1, sample_t'($urandom), SLOT - 1);
        slot(1'b0, sample_t'($urandom), SLOT - 1);
        slot(1'b1, sample_t'($urandom), SLOT - 1);
        slot(1'b0, sample_t'($urandom), SLOT - 1);
        chk("queue_drained", q_l.size(), 0);
        stim_done = 1'b1;
      end
      begin : monitor
        bit prev_v;
        sample_t el, er;
        prev_v = 1'b0;
        exp_l = '0;
        exp_r = '0;
        while (!stim_done) begin
          @(posedge clk);
          #1;
          if (!reset) begin
            exp_l = '0; exp_r = '0;
            q_l.delete(); q_r.delete();
          end
          if (sample_valid) begin
            chk("valid_pulse_width", int'(prev_v), 0);
            if (q_l.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid: got left %h right %h with no pair expected", left_out, right_out);
            end else begin
              el = q_l.pop_front();
              er = q_r.pop_front();
              chk("left_out", int'(left_out), int'(el));
              chk("right_out", int'(right_out), int'(er));
              chk("latency", cyc - rise_edge, SS + 2);
              exp_l = el;
              exp_r = er;
            end
          end else begin
            chk("hold_left", int'(left_out), int'(exp_l));
            chk("hold_right", int'(right_out), int'(exp_r));
          end
          prev_v = sample_valid;
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
